// File: rtl/button_pulse_gen.sv
// Pushbutton front end: synchronise, debounce and auto-repeat two raw keys into
// single-clock increment/decrease pulses, with both-pressed lockout.
module button_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_inc,
  input  logic btn_dec,
  output logic increment,
  output logic decrease,
  output logic inc_held,
  output logic dec_held
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int TM_W = $clog2(TMAX + 1);
  localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TM_W-1:0] DELAY_LAST = TM_W'(REPEAT_DELAY - 1);
  localparam logic [TM_W-1:0] RATE_LAST  = TM_W'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT, LOCK} state_t;

  // Channel index 0 is the increment button, 1 is the decrease button.
  logic [1:0]      sync1, sync2, level, deb, held, pulse, pulse_nx;
  logic [DB_W-1:0] db_cnt   [2];
  logic [TM_W-1:0] timer    [2];
  logic [TM_W-1:0] timer_nx [2];
  state_t          state    [2];
  state_t          state_nx [2];
  logic            both_held, both_released;

  assign level         = sync2 ^ {2{BTN_ACTIVE_LOW}};
  assign both_held     = held[0] & held[1];
  assign both_released = ~(held[0] | held[1]);

  // Sync flops reset to the raw released level so a key held through reset re-debounces.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1     <= {2{BTN_ACTIVE_LOW}};
      sync2     <= {2{BTN_ACTIVE_LOW}};
      deb       <= '0;
      held      <= '0;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      sync1 <= {btn_dec, btn_inc};
      sync2 <= sync1;
      held  <= deb;
      for (int ch = 0; ch < 2; ch++) begin
        if (level[ch] == deb[ch]) begin
          db_cnt[ch] <= '0;
        end else if (db_cnt[ch] == DB_LAST) begin
          deb[ch]    <= ~deb[ch];
          db_cnt[ch] <= '0;
        end else begin
          db_cnt[ch] <= db_cnt[ch] + DB_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state[0] <= IDLE;
      state[1] <= IDLE;
      timer[0] <= '0;
      timer[1] <= '0;
      pulse    <= '0;
    end else begin
      state[0] <= state_nx[0];
      state[1] <= state_nx[1];
      timer[0] <= timer_nx[0];
      timer[1] <= timer_nx[1];
      pulse    <= pulse_nx;
    end
  end

  // A due pulse waits one extra clock if the previous one is still high, so a
  // rate of 1 degrades to every other clock instead of a stuck-high output.
  always_comb begin
    pulse_nx = '0;
    for (int ch = 0; ch < 2; ch++) begin
      state_nx[ch] = state[ch];
      timer_nx[ch] = timer[ch];
      if (both_held && state[ch] != LOCK) begin
        state_nx[ch] = LOCK;
        timer_nx[ch] = '0;
      end else begin
        case (state[ch])
          IDLE: begin
            if (held[ch]) begin
              pulse_nx[ch] = 1'b1;
              timer_nx[ch] = '0;
              state_nx[ch] = DELAY;
            end
          end
          DELAY, REPEAT: begin
            if (!held[ch]) begin
              state_nx[ch] = IDLE;
              timer_nx[ch] = '0;
            end else if (!pulse[ch] &&
                         timer[ch] >= ((state[ch] == DELAY) ? DELAY_LAST : RATE_LAST)) begin
              pulse_nx[ch] = 1'b1;
              timer_nx[ch] = '0;
              state_nx[ch] = REPEAT;
            end else begin
              timer_nx[ch] = timer[ch] + TM_W'(1);
            end
          end
          LOCK: begin
            if (both_released) state_nx[ch] = IDLE;
          end
          default: state_nx[ch] = IDLE;
        endcase
      end
    end
  end

  assign increment = pulse[0];
  assign decrease  = pulse[1];
  assign inc_held  = held[0];
  assign dec_held  = held[1];

endmodule
